dcache_flush_unit: RTL
======================

Name: dcache_flush_unit

Overview:
Downstream consumer of the flush controller's registered dcache-flush request, sitting inside the write-back dcache. On request it walks every set, writes back all valid and dirty lines, and invalidates each set. It then returns a single-cycle acknowledge, which the controller uses to release its fence-active halt.

Parameters:
NR_SETS, 256, number of cache sets; power of two, at least 2. Derived IDX_W = $clog2(NR_SETS).
NR_WAYS, 8, ways per set; at least 1. Derived WAY_W = max(1, $clog2(NR_WAYS)).
TAG_W, 44, tag width in bits.
OFFSET_W, 4, byte-offset bits per line. Derived PADDR_W = TAG_W + IDX_W + OFFSET_W.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
flush_i  in  1  flush request; level signal held high until ack.
flush_ack_o  out  1  one-cycle pulse when flush is complete.
busy_o  out  1  high whenever the FSM is not in IDLE.
tag_req_o  out  1  tag/status array read request.
tag_index_o  out  IDX_W  set index to read or invalidate.
tag_gnt_i  in  1  read grant; data is valid on the cycle after the grant.
valid_i  in  NR_WAYS  per-way valid bits, returned one cycle after grant.
dirty_i  in  NR_WAYS  per-way dirty bits, returned one cycle after grant.
tag_i  in  NR_WAYS*TAG_W  per-way tags; way w occupies bits [w*TAG_W +: TAG_W].
wb_valid_o  out  1  writeback request valid.
wb_ready_i  in  1  writeback request accepted.
wb_addr_o  out  PADDR_W  line address {tag, index, OFFSET_W'b0}.
wb_way_o  out  WAY_W  way being written back.
inv_req_o  out  1  invalidate all ways of tag_index_o.
inv_gnt_i  in  1  invalidate accepted.

Behaviour:
- Reset is asynchronous. It forces state IDLE, clears the index counter and the captured mask/tags, and drives every output to 0.
- FSM states: IDLE, READ, WAIT, SCAN, INV, DONE, HOLD.
- IDLE: when flush_i=1, go to READ with index=0.
- READ: tag_req_o=1 and tag_index_o=index. On tag_gnt_i=1, go to WAIT.
- WAIT: capture pend = valid_i & dirty_i and capture all tags. If pend==0, go to INV; otherwise go to SCAN.
- SCAN:
  - wb_valid_o=1; wb_way_o = lowest set bit of pend; wb_addr_o = {tag[way], index, 0}.
  - Request fields are held stable while wb_ready_i=0.
  - On wb_ready_i=1, clear that bit of pend. If the new pend==0, go to INV; otherwise stay and present the next way in the following cycle.
- INV: inv_req_o=1 and tag_index_o=index. On inv_gnt_i=1: if index==NR_SETS-1, go to DONE; otherwise increment index and go to READ.
- DONE: flush_ack_o=1 for exactly this one cycle, driven from registered state with no combinational path from inputs. Go to HOLD.
- HOLD: one dead cycle that ignores flush_i, then IDLE.
  - Reason: the controller sees the ack at cycle t and its registered request is still high at t+1. Sampling only from t+2 prevents a spurious second flush.
  - A request still high at t+2 is a genuine new fence and starts a new walk.
- Per-set cost with all grants and ready tied high: 3 cycles (READ, WAIT, INV) plus 1 cycle per dirty line.
- Lines that are valid but clean get no writeback. Lines that are dirty but invalid are ignored.
- The index counter runs from 0 to NR_SETS-1 only and never wraps within a walk.
- If flush_i drops mid-walk, the walk still completes and acks. flush_i is sampled only in IDLE.
- Reset mid-walk abandons the walk immediately: no ack, no partial request held, and the next flush restarts from index 0.
- busy_o = (state != IDLE).

Test Plan:
- Config NR_SETS=4, NR_WAYS=2, OFFSET_W=4; all grants and ready tied 1; cache clean; flush_i rises at cycle 0 -> exactly one flush_ack_o pulse at cycle 13, and wb_valid_o never asserts.
- Same config; set 2 has way0 dirty tag 0x5 and way1 dirty tag 0x9 -> writebacks in order 0x160 (way0) then 0x260 (way1), and the ack arrives at cycle 15.
- Hold wb_ready_i=0 for 5 cycles during a writeback -> wb_valid_o, wb_addr_o and wb_way_o remain stable for all 5 cycles; the ack is delayed by exactly 5 cycles.
- flush_i high through ack+1 then low -> no second walk starts. flush_i high at ack+2 -> a second walk starts with index 0.
- Assert rst_ni low during SCAN of set 1 -> all outputs are 0 asynchronously and no ack is issued. A new flush walks from set 0.
- Way0 valid and clean, way1 dirty and invalid, in every set -> no writebacks, and each set receives exactly one inv_req_o.

Source files
------------

// File: rtl/dcache_flush_unit_if.sv
// Bundle between the dcache flush unit, the flush controller and the tag/writeback ports.
// Signal suffixes follow the flush unit's point of view; master is the flush unit.
interface dcache_flush_unit_if #(
    parameter int NR_SETS  = 256,
    parameter int NR_WAYS  = 8,
    parameter int TAG_W    = 44,
    parameter int OFFSET_W = 4
);
    localparam int IDX_W   = $clog2(NR_SETS);
    localparam int WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int PADDR_W = TAG_W + IDX_W + OFFSET_W;

    logic                     flush_i;
    logic                     flush_ack_o;
    logic                     busy_o;

    logic                     tag_req_o;
    logic [IDX_W-1:0]         tag_index_o;
    logic                     tag_gnt_i;
    logic [NR_WAYS-1:0]       valid_i;
    logic [NR_WAYS-1:0]       dirty_i;
    logic [NR_WAYS*TAG_W-1:0] tag_i;

    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [PADDR_W-1:0]       wb_addr_o;
    logic [WAY_W-1:0]         wb_way_o;

    logic                     inv_req_o;
    logic                     inv_gnt_i;

    modport master (
        input  flush_i, tag_gnt_i, valid_i, dirty_i, tag_i, wb_ready_i, inv_gnt_i,
        output flush_ack_o, busy_o, tag_req_o, tag_index_o, wb_valid_o, wb_addr_o,
               wb_way_o, inv_req_o
    );

    modport slave (
        output flush_i, tag_gnt_i, valid_i, dirty_i, tag_i, wb_ready_i, inv_gnt_i,
        input  flush_ack_o, busy_o, tag_req_o, tag_index_o, wb_valid_o, wb_addr_o,
               wb_way_o, inv_req_o
    );
endinterface

// File: rtl/dcache_flush_unit.sv
// Walks every dcache set on a flush request, writes back valid+dirty lines lowest way
// first, invalidates each set, then pulses a registered acknowledge.
module dcache_flush_unit #(
    parameter int NR_SETS  = 256,
    parameter int NR_WAYS  = 8,
    parameter int TAG_W    = 44,
    parameter int OFFSET_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dcache_flush_unit_if.master   bus
);
    localparam int IDX_W   = $clog2(NR_SETS);
    localparam int WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int PADDR_W = TAG_W + IDX_W + OFFSET_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SCAN = 3'd3,
        INV  = 3'd4,
        DONE = 3'd5,
        HOLD = 3'd6
    } state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NR_WAYS-1:0]              pend_q, pend_d;
    logic [NR_WAYS-1:0][TAG_W-1:0]   tags_q, tags_d;

    logic [WAY_W-1:0]                way_sel;
    logic [NR_WAYS-1:0]              way_oh;

    // Lowest pending way wins; descending loop lets the last hit stick.
    always_comb begin
        way_sel = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (pend_q[w]) way_sel = WAY_W'(w);
        end
        way_oh          = '0;
        way_oh[way_sel] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            tags_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            tags_q  <= tags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        tags_d  = tags_q;
        unique case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (bus.tag_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                pend_d  = bus.valid_i & bus.dirty_i;
                tags_d  = bus.tag_i;
                state_d = (|(bus.valid_i & bus.dirty_i)) ? SCAN : INV;
            end
            SCAN: begin
                if (bus.wb_ready_i) begin
                    pend_d = pend_q & ~way_oh;
                    if (pend_d == '0) state_d = INV;
                end
            end
            INV: begin
                if (bus.inv_gnt_i) begin
                    if (idx_q == IDX_W'(NR_SETS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = HOLD;
            // The controller's registered request is still high here; drop it.
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.flush_ack_o = 1'b0;
        bus.busy_o      = (state_q != IDLE);
        bus.tag_req_o   = 1'b0;
        bus.tag_index_o = '0;
        bus.wb_valid_o  = 1'b0;
        bus.wb_addr_o   = '0;
        bus.wb_way_o    = '0;
        bus.inv_req_o   = 1'b0;
        unique case (state_q)
            READ: begin
                bus.tag_req_o   = 1'b1;
                bus.tag_index_o = idx_q;
            end
            SCAN: begin
                bus.wb_valid_o = 1'b1;
                bus.wb_way_o   = way_sel;
                bus.wb_addr_o  = PADDR_W'({tags_q[way_sel], idx_q, {OFFSET_W{1'b0}}});
            end
            INV: begin
                bus.inv_req_o   = 1'b1;
                bus.tag_index_o = idx_q;
            end
            DONE:    bus.flush_ack_o = 1'b1;
            default: ;
        endcase
    end
endmodule
